// File: rtl/alarm_ctrl_if.sv
// Bundle between the timekeeping stage / front panel and the alarm stage.
// The master side owns the mode, keys and running time; the slave owns alarm state and buzzer.
interface alarm_ctrl_if;
   logic [3:0] state_mode;
   logic       AH_key;
   logic       AM_key;
   logic       stop_key;
   logic       snooze_key;
   logic [7:0] hour_time;
   logic [7:0] minute_time;
   logic [7:0] second_time;
   logic [7:0] alarm_hour;
   logic [7:0] alarm_minute;
   logic       alarm_en;
   logic       ringing;
   logic       snoozing;
   logic       buzzer;

   modport master (
      output state_mode, AH_key, AM_key, stop_key, snooze_key,
      output hour_time, minute_time, second_time,
      input  alarm_hour, alarm_minute, alarm_en, ringing, snoozing, buzzer
   );

   modport slave (
      input  state_mode, AH_key, AM_key, stop_key, snooze_key,
      input  hour_time, minute_time, second_time,
      output alarm_hour, alarm_minute, alarm_en, ringing, snoozing, buzzer
   );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm stage: holds the alarm time, detects the minute match and drives a
// gated 1 kHz buzzer through an IDLE / RING / SNOOZE state machine.
module alarm_ctrl #(
   parameter int unsigned TONE_DIV    = 25000,
   parameter int unsigned RING_SECS   = 60,
   parameter int unsigned SNOOZE_SECS = 300,
   parameter int unsigned RST_AH      = 7,
   parameter int unsigned RST_AM      = 0
) (
   input  logic         clk_50M,
   input  logic         rst_n,
   input  logic         clk_1Hz,
   alarm_ctrl_if.slave  bus
);

   localparam int unsigned NUM_KEYS = 4;
   localparam int unsigned KEY_AH     = 0;
   localparam int unsigned KEY_AM     = 1;
   localparam int unsigned KEY_STOP   = 2;
   localparam int unsigned KEY_SNOOZE = 3;

   localparam int unsigned DIV_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TONE_DIV - 1);
   localparam logic [15:0]      RING_LAST   = 16'(RING_SECS - 1);
   localparam logic [15:0]      SNOOZE_LAST = 16'(SNOOZE_SECS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] key_press;

   logic       ah_press;
   logic       am_press;
   logic       stop_press;
   logic       snooze_press;
   logic       mode_tset;
   logic       mode_aset;

   logic [7:0] alarm_hour_reg;
   logic [7:0] alarm_minute_reg;
   logic       alarm_en_reg;

   logic       match;
   logic       match_d_reg;
   logic       trigger;

   state_t     state_reg;
   logic [15:0] cnt_reg;
   logic       beep_reg;
   logic       ringing_reg;
   logic       snoozing_reg;
   logic       buzzer_reg;

   logic [DIV_W-1:0] div_reg;
   logic             tone_sq_reg;

   assign key_raw[KEY_AH]     = bus.AH_key;
   assign key_raw[KEY_AM]     = bus.AM_key;
   assign key_raw[KEY_STOP]   = bus.stop_key;
   assign key_raw[KEY_SNOOZE] = bus.snooze_key;

   // Sync flops reset high (idle level) so releasing reset never looks like a press.
   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_sync
         logic buf0_reg;
         logic buf1_reg;

         always_ff @(posedge clk_50M or negedge rst_n) begin
            if (!rst_n) begin
               buf0_reg <= 1'b1;
               buf1_reg <= 1'b1;
            end else begin
               buf0_reg <= key_raw[gi];
               buf1_reg <= buf0_reg;
            end
         end

         assign key_press[gi] = !buf0_reg && buf1_reg;
      end
   endgenerate

   assign ah_press     = key_press[KEY_AH];
   assign am_press     = key_press[KEY_AM];
   assign stop_press   = key_press[KEY_STOP];
   assign snooze_press = key_press[KEY_SNOOZE];

   assign mode_tset = (bus.state_mode == 4'd1);
   assign mode_aset = (bus.state_mode == 4'd2);

   // Hour and minute roll over independently; a minute wrap never carries.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         alarm_hour_reg   <= 8'(RST_AH);
         alarm_minute_reg <= 8'(RST_AM);
         alarm_en_reg     <= 1'b0;
      end else begin
         if (mode_aset && ah_press) begin
            alarm_hour_reg <= (alarm_hour_reg == 8'd23) ? 8'd0 : alarm_hour_reg + 8'd1;
         end
         if (mode_aset && am_press) begin
            alarm_minute_reg <= (alarm_minute_reg == 8'd59) ? 8'd0 : alarm_minute_reg + 8'd1;
         end
         if (mode_aset && stop_press && (state_reg == IDLE)) begin
            alarm_en_reg <= !alarm_en_reg;
         end
      end
   end

   assign match = alarm_en_reg
                  && (bus.hour_time   == alarm_hour_reg)
                  && (bus.minute_time == alarm_minute_reg)
                  && (bus.second_time == 8'd0);

   assign trigger = match && !match_d_reg;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         match_d_reg <= 1'b0;
      end else begin
         match_d_reg <= match;
      end
   end

   // Outputs decode the current state register, so they trail a transition by one cycle.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= 16'd0;
         beep_reg     <= 1'b0;
         ringing_reg  <= 1'b0;
         snoozing_reg <= 1'b0;
         buzzer_reg   <= 1'b0;
      end else begin
         ringing_reg  <= (state_reg == RING);
         snoozing_reg <= (state_reg == SNOOZE);
         buzzer_reg   <= (state_reg == RING) && beep_reg && tone_sq_reg;

         case (state_reg)
            IDLE: begin
               if (!mode_tset && trigger) begin
                  state_reg <= RING;
                  cnt_reg   <= 16'd0;
                  beep_reg  <= 1'b1;
               end
            end

            RING: begin
               if (mode_tset || stop_press) begin
                  state_reg <= IDLE;
                  cnt_reg   <= 16'd0;
                  beep_reg  <= 1'b0;
               end else if (snooze_press) begin
                  state_reg <= SNOOZE;
                  cnt_reg   <= 16'd0;
               end else if (clk_1Hz) begin
                  if (cnt_reg == RING_LAST) begin
                     state_reg <= IDLE;
                     cnt_reg   <= 16'd0;
                     beep_reg  <= 1'b0;
                  end else begin
                     cnt_reg  <= cnt_reg + 16'd1;
                     beep_reg <= !beep_reg;
                  end
               end
            end

            SNOOZE: begin
               if (mode_tset || stop_press) begin
                  state_reg <= IDLE;
                  cnt_reg   <= 16'd0;
                  beep_reg  <= 1'b0;
               end else if (clk_1Hz) begin
                  if (cnt_reg == SNOOZE_LAST) begin
                     state_reg <= RING;
                     cnt_reg   <= 16'd0;
                     beep_reg  <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + 16'd1;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt_reg   <= 16'd0;
               beep_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Tone divider only runs while ringing so every ring starts from the same phase.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         div_reg     <= '0;
         tone_sq_reg <= 1'b0;
      end else if (state_reg != RING) begin
         div_reg     <= '0;
         tone_sq_reg <= 1'b0;
      end else if (div_reg == DIV_LAST) begin
         div_reg     <= '0;
         tone_sq_reg <= !tone_sq_reg;
      end else begin
         div_reg <= div_reg + DIV_W'(1);
      end
   end

   assign bus.alarm_hour   = alarm_hour_reg;
   assign bus.alarm_minute = alarm_minute_reg;
   assign bus.alarm_en     = alarm_en_reg;
   assign bus.ringing      = ringing_reg;
   assign bus.snoozing     = snoozing_reg;
   assign bus.buzzer       = buzzer_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with shortened tone/ring/snooze constants.
module tb_alarm_ctrl;

   localparam int unsigned TONE_DIV    = 3;
   localparam int unsigned RING_SECS   = 4;
   localparam int unsigned SNOOZE_SECS = 3;

   logic clk_50M = 1'b0;
   logic rst_n;
   logic clk_1Hz;
   int   checks = 0;
   int   errors = 0;
   int   hi_cnt;

   alarm_ctrl_if bus ();

   alarm_ctrl #(
      .TONE_DIV    (TONE_DIV),
      .RING_SECS   (RING_SECS),
      .SNOOZE_SECS (SNOOZE_SECS),
      .RST_AH      (7),
      .RST_AM      (0)
   ) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .clk_1Hz (clk_1Hz),
      .bus     (bus)
   );

   always #5 clk_50M = ~clk_50M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   // mask bits: 0 AH, 1 AM, 2 stop, 3 snooze
   task automatic press(input logic [3:0] mask);
      @(negedge clk_50M);
      if (mask[0]) bus.AH_key     = 1'b0;
      if (mask[1]) bus.AM_key     = 1'b0;
      if (mask[2]) bus.stop_key   = 1'b0;
      if (mask[3]) bus.snooze_key = 1'b0;
      step(3);
      bus.AH_key = 1'b1; bus.AM_key = 1'b1; bus.stop_key = 1'b1; bus.snooze_key = 1'b1;
      step(3);
   endtask

   task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      @(negedge clk_50M);
      bus.hour_time = h; bus.minute_time = m; bus.second_time = s;
   endtask

   task automatic tick();
      @(negedge clk_50M);
      clk_1Hz = 1'b1;
      @(negedge clk_50M);
      clk_1Hz = 1'b0;
      step(2);
   endtask

   task automatic do_reset();
      @(negedge clk_50M);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
   endtask

   // Re-arm the minute match by stepping the seconds off and back onto zero.
   task automatic retrigger(input logic [7:0] h, input logic [7:0] m);
      set_time(h, m, 8'd1);
      step(2);
      set_time(h, m, 8'd0);
      step(3);
   endtask

   initial begin
      rst_n = 1'b0; clk_1Hz = 1'b0;
      bus.state_mode = 4'd0;
      bus.AH_key = 1'b1; bus.AM_key = 1'b1; bus.stop_key = 1'b1; bus.snooze_key = 1'b1;
      bus.hour_time = 8'd0; bus.minute_time = 8'd0; bus.second_time = 8'd0;
      step(3);
      check("rst_alarm_hour",   bus.alarm_hour,   7);
      check("rst_alarm_minute", bus.alarm_minute, 0);
      check("rst_alarm_en",     bus.alarm_en,     0);
      check("rst_ringing",      bus.ringing,      0);
      check("rst_buzzer",       bus.buzzer,       0);
      @(negedge clk_50M);
      rst_n = 1'b1;
      step(2);

      press(4'b0001);
      check("mode0_ah_locked", bus.alarm_hour, 7);

      bus.state_mode = 4'd2;
      for (int i = 0; i < 16; i++) press(4'b0001);
      check("ah_at_23", bus.alarm_hour, 23);
      press(4'b0001);
      check("ah_wrap_0", bus.alarm_hour, 0);
      for (int i = 0; i < 7; i++) press(4'b0001);
      check("ah_24_presses", bus.alarm_hour, 7);
      for (int i = 0; i < 59; i++) press(4'b0010);
      check("am_at_59", bus.alarm_minute, 59);
      for (int i = 0; i < 2; i++) press(4'b0010);
      check("am_61_presses", bus.alarm_minute, 1);
      check("am_no_carry", bus.alarm_hour, 7);
      check("en_still_0", bus.alarm_en, 0);
      press(4'b0011);
      check("ah_am_same_hour", bus.alarm_hour, 8);
      check("ah_am_same_min",  bus.alarm_minute, 2);

      do_reset();
      check("reset2_hour", bus.alarm_hour, 7);
      check("reset2_min",  bus.alarm_minute, 0);
      bus.state_mode = 4'd2;
      press(4'b0100);
      check("en_toggle_on", bus.alarm_en, 1);
      press(4'b0100);
      check("en_toggle_off", bus.alarm_en, 0);
      press(4'b0100);
      check("en_toggle_on2", bus.alarm_en, 1);

      bus.state_mode = 4'd0;
      set_time(8'd6, 8'd59, 8'd59);
      step(3);
      check("pre_match_idle", bus.ringing, 0);
      set_time(8'd7, 8'd0, 8'd0);
      step(2);
      check("ring_2_cycles", bus.ringing, 1);
      step(3);
      check("tone_high_c4", bus.buzzer, 1);
      step(2);
      check("tone_high_c6", bus.buzzer, 1);
      step(1);
      check("tone_low_c7", bus.buzzer, 0);
      step(3);
      check("tone_high_c10", bus.buzzer, 1);

      tick();
      hi_cnt = 0;
      repeat (2 * TONE_DIV + 2) begin
         step(1);
         if (bus.buzzer) hi_cnt++;
      end
      check("odd_beep_silent", hi_cnt, 0);
      tick();
      hi_cnt = 0;
      repeat (2 * TONE_DIV + 2) begin
         step(1);
         if (bus.buzzer) hi_cnt++;
      end
      check("even_beep_tone", (hi_cnt != 0), 1);
      tick();
      check("ring_after_3_ticks", bus.ringing, 1);
      tick();
      check("ring_timeout", bus.ringing, 0);
      check("timeout_buzzer", bus.buzzer, 0);
      step(10);
      check("no_retrigger", bus.ringing, 0);

      retrigger(8'd7, 8'd0);
      check("ring_again", bus.ringing, 1);
      press(4'b1000);
      check("snooze_flag", bus.snoozing, 1);
      check("snooze_not_ring", bus.ringing, 0);
      check("snooze_buzzer", bus.buzzer, 0);
      tick();
      tick();
      check("snooze_2_ticks", bus.snoozing, 1);
      tick();
      check("snooze_rering", bus.ringing, 1);
      check("snooze_cleared", bus.snoozing, 0);
      press(4'b0100);
      check("stop_idle", bus.ringing, 0);
      check("stop_keeps_en", bus.alarm_en, 1);

      retrigger(8'd7, 8'd0);
      check("ring_for_both", bus.ringing, 1);
      press(4'b1100);
      check("stop_snooze_ring", bus.ringing, 0);
      check("stop_snooze_snz", bus.snoozing, 0);

      retrigger(8'd7, 8'd0);
      check("ring_for_tset", bus.ringing, 1);
      @(negedge clk_50M);
      bus.state_mode = 4'd1;
      step(2);
      check("tset_abort", bus.ringing, 0);
      bus.state_mode = 4'd0;
      step(3);
      check("tset_no_retrig", bus.ringing, 0);

      bus.state_mode = 4'd2;
      press(4'b0001);
      press(4'b0010);
      check("edit_hour_8", bus.alarm_hour, 8);
      check("edit_min_1",  bus.alarm_minute, 1);
      bus.state_mode = 4'd0;
      retrigger(8'd8, 8'd1);
      check("ring_0801", bus.ringing, 1);
      for (int i = 0; i < 20; i++) begin
         if (bus.buzzer) break;
         step(1);
      end
      check("buzz_before_rst", bus.buzzer, 1);
      @(negedge clk_50M);
      rst_n = 1'b0;
      #1;
      check("async_buzzer", bus.buzzer, 0);
      check("async_ringing", bus.ringing, 0);
      check("async_hour", bus.alarm_hour, 7);
      check("async_min", bus.alarm_minute, 0);
      check("async_en", bus.alarm_en, 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
